// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state encoding and
// default memory-map parameters used across the pipeline.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLow  = 2'd1,
    StHigh = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam int unsigned AccessCyclesDefault = 2;
  localparam int unsigned MemBaseDefault      = 1024;
  localparam int unsigned SramAwDefault       = 18;

endpackage

// File: rtl/sram_wait_cnt.sv
// Phase wait counter: counts cycles within one SRAM half-word phase and flags
// the final cycle of the phase.
module sram_wait_cnt #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic last_cycle_o
);

  localparam int unsigned CntW = $clog2(ACCESS_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(ACCESS_CYCLES - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Wraps to zero on the last cycle so each phase starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_cycle_o = (cnt_q == CntLast);

endmodule

// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit phases on an asynchronous SRAM and stalls the pipeline via ready.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = AccessCyclesDefault,
  parameter int unsigned MEM_BASE      = MemBaseDefault,
  parameter int unsigned SRAM_AW       = SramAwDefault
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN,
  input  logic               MEM_W_EN,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N
);

  state_e             state_d, state_q;
  logic               op_wr_d, op_wr_q;
  logic [SRAM_AW-2:0] word_d, word_q;
  logic [31:0]        wdata_d, wdata_q;
  logic [31:0]        rdata_d, rdata_q;
  logic [31:0]        mem_off;
  logic               ready_c;
  logic               in_phase;
  logic               last_cycle;
  logic               dq_oe;
  logic [15:0]        dq_out;
  logic               unused_addr_bits;

  assign mem_off          = address - MEM_BASE;
  assign unused_addr_bits = ^{mem_off[31:SRAM_AW+1], mem_off[1:0]};
  assign in_phase         = (state_q == StLow) || (state_q == StHigh);

  sram_wait_cnt #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait_cnt (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (~in_phase),
    .en_i         (in_phase),
    .last_cycle_o (last_cycle)
  );

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ready_c = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_c = ~(MEM_R_EN | MEM_W_EN);
        if (MEM_R_EN || MEM_W_EN) begin
          op_wr_d = MEM_W_EN;
          word_d  = mem_off[SRAM_AW:2];
          wdata_d = wdata;
          state_d = StLow;
        end
      end
      StLow: begin
        if (last_cycle) begin
          if (!op_wr_q) rdata_d[15:0] = SRAM_DQ;
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (last_cycle) begin
          if (!op_wr_q) rdata_d[31:16] = SRAM_DQ;
          state_d = StDone;
        end
      end
      StDone: begin
        ready_c = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    SRAM_ADDR = '0;
    unique case (state_q)
      StLow:   SRAM_ADDR = {word_q, 1'b0};
      StHigh:  SRAM_ADDR = {word_q, 1'b1};
      default: SRAM_ADDR = '0;
    endcase
  end

  // Reset aborts a write immediately: strobe and bus are released in the reset cycle.
  assign dq_oe     = in_phase & op_wr_q & ~rst;
  assign dq_out    = (state_q == StHigh) ? wdata_q[31:16] : wdata_q[15:0];
  assign SRAM_WE_N = ~(dq_oe & ~last_cycle);
  assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;

  // Nothing is pending while reset is held, so the pipeline is not frozen.
  assign ready = ready_c | rst;
  assign rdata = rdata_q;

  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Directed bench for sram_mem_ctrl with a small behavioural SRAM on the DQ bus.
module tb_sram_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  wire  [31:0] rdata;
  wire         ready;
  wire  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         we_n, ub_n, lb_n, ce_n, oe_n;

  int total = 0;
  int bad   = 0;

  logic [15:0] sram_mem [16];
  logic        rd_window = 1'b0;

  always #5 clk = ~clk;

  assign sram_dq = (rd_window && we_n) ? sram_mem[sram_addr[3:0]] : 16'bz;

  always @(posedge clk) begin
    if (!we_n) sram_mem[sram_addr[3:0]] <= sram_dq;
  end

  sram_mem_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .MEM_R_EN  (mem_r_en),
    .MEM_W_EN  (mem_w_en),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .SRAM_DQ   (sram_dq),
    .SRAM_ADDR (sram_addr),
    .SRAM_WE_N (we_n),
    .SRAM_UB_N (ub_n),
    .SRAM_LB_N (lb_n),
    .SRAM_CE_N (ce_n),
    .SRAM_OE_N (oe_n)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic bus_free(input logic [15:0] v);
    return (v === 16'hzzzz) || (v === 16'h0000);
  endfunction

  initial begin
    // Reset held two cycles with a load request pending.
    mem_r_en = 1'b1;
    address  = 32'd1032;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check_eq("rst_ready", 32'(ready), 32'd1);
      check_eq("rst_we_n", 32'(we_n), 32'd1);
      check_eq("rst_dq_free", 32'(bus_free(sram_dq)), 32'd1);
      check_eq("rst_rdata", rdata, 32'h0);
      check_eq("rst_addr", 32'(sram_addr), 32'd0);
    end
    @(negedge clk); rst = 1'b0; #1;
    check_eq("rel_ready", 32'(ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); mem_r_en = 1'b0; #1;
      check_eq("rel_ready_seq", 32'(ready), (k == 5) ? 32'd1 : 32'd0);
    end

    // Store 0xDEADBEEF at 1032; inputs scrambled after cycle 0.
    @(negedge clk);
    mem_w_en = 1'b1; address = 32'd1032; wdata = 32'hDEADBEEF; #1;
    check_eq("st_c0_ready", 32'(ready), 32'd0);
    check_eq("st_c0_we_n", 32'(we_n), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin mem_w_en = 1'b0; address = 32'd0; wdata = 32'h0; end
      #1;
      if (k < 5) begin
        check_eq("st_addr", 32'(sram_addr), (k < 3) ? 32'd4 : 32'd5);
        check_eq("st_dq", 32'(sram_dq), (k < 3) ? 32'h0000BEEF : 32'h0000DEAD);
        check_eq("st_we_n", 32'(we_n), (k % 2 == 1) ? 32'd0 : 32'd1);
        check_eq("st_ready", 32'(ready), 32'd0);
      end else begin
        check_eq("st_done_ready", 32'(ready), 32'd1);
        check_eq("st_done_dq_free", 32'(bus_free(sram_dq)), 32'd1);
        check_eq("st_rdata_kept", rdata, 32'h0);
      end
    end
    @(negedge clk); #1;
    check_eq("st_idle_ready", 32'(ready), 32'd1);

    // Load back from 1032.
    rd_window = 1'b1;
    @(negedge clk);
    mem_r_en = 1'b1; address = 32'd1032; wdata = 32'h12345678; #1;
    check_eq("ld_c0_ready", 32'(ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin mem_r_en = 1'b0; address = 32'd0; end
      #1;
      check_eq("ld_we_n", 32'(we_n), 32'd1);
      check_eq("ld_ready", 32'(ready), (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) check_eq("ld_addr", 32'(sram_addr), (k < 3) ? 32'd4 : 32'd5);
      else       check_eq("ld_rdata", rdata, 32'hDEADBEEF);
    end
    rd_window = 1'b0;

    // Read and write together: the write wins and rdata is untouched.
    @(negedge clk);
    mem_r_en = 1'b1; mem_w_en = 1'b1; address = 32'd1036; wdata = 32'hCAFEF00D; #1;
    check_eq("rw_c0_ready", 32'(ready), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin mem_r_en = 1'b0; mem_w_en = 1'b0; end
      #1;
      if (k == 1) begin
        check_eq("rw_we_n", 32'(we_n), 32'd0);
        check_eq("rw_dq_lo", 32'(sram_dq), 32'h0000F00D);
        check_eq("rw_addr_lo", 32'(sram_addr), 32'd6);
      end
      if (k == 3) begin
        check_eq("rw_dq_hi", 32'(sram_dq), 32'h0000CAFE);
        check_eq("rw_addr_hi", 32'(sram_addr), 32'd7);
      end
      if (k == 5) begin
        check_eq("rw_ready", 32'(ready), 32'd1);
        check_eq("rw_rdata_kept", rdata, 32'hDEADBEEF);
        check_eq("rw_mem_lo", 32'(sram_mem[6]), 32'h0000F00D);
        check_eq("rw_mem_hi", 32'(sram_mem[7]), 32'h0000CAFE);
      end
    end

    // Back-to-back loads: held through DONE, new address in the next cycle.
    rd_window = 1'b1;
    @(negedge clk);
    mem_r_en = 1'b1; address = 32'd1036;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 6) address = 32'd1032;
      #1;
      check_eq("b2b_ready", 32'(ready), (k == 5 || k == 11) ? 32'd1 : 32'd0);
      if (k == 5)  check_eq("b2b_rdata1", rdata, 32'hCAFEF00D);
      if (k == 11) check_eq("b2b_rdata2", rdata, 32'hDEADBEEF);
    end
    @(negedge clk); mem_r_en = 1'b0; rd_window = 1'b0; #1;
    check_eq("b2b_idle_ready", 32'(ready), 32'd1);

    // Reset in the HIGH phase of a write.
    @(negedge clk);
    mem_w_en = 1'b1; address = 32'd1040; wdata = 32'h55AA33CC; #1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) mem_w_en = 1'b0;
      #1;
    end
    check_eq("mid_addr_hi", 32'(sram_addr), 32'd9);
    check_eq("mid_we_n_hi", 32'(we_n), 32'd0);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check_eq("mid_ready", 32'(ready), 32'd1);
    check_eq("mid_we_n", 32'(we_n), 32'd1);
    check_eq("mid_dq_free", 32'(bus_free(sram_dq)), 32'd1);
    check_eq("mid_rdata_clr", rdata, 32'h0);
    check_eq("mid_addr", 32'(sram_addr), 32'd0);
    @(negedge clk); #1;
    check_eq("mid_idle_ready", 32'(ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
